if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 16 +
 rtl/if_stage_pc_reg.sv | 25 ++
 rtl/if_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the fetch stage: word width, bubble encoding, FSM states.
package if_stage_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned FSM_W  = 2;

    // Bubble: opcode 5'b00001, all other fields zero
    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0800;

    typedef enum logic [FSM_W-1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter: load has priority over increment, otherwise hold; wraps silently.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_pc,
    input  logic              inc,
    output logic [WORD_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + WORD_W'(1);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register, fetch FSM and stall counter.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_stall,
    input  logic              stall_ifid,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr_id,
    output logic [WORD_W-1:0] pc_id,
    output logic [WORD_W-1:0] pc_plus1_id,
    output logic              valid_id,
    output logic [FSM_W-1:0]  fetch_state,
    output logic [WORD_W-1:0] stall_cnt
);

    fetch_state_e      state_q;
    fetch_state_e      state_nxt;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus1;
    logic              hold;
    logic              pc_load;
    logic              pc_inc;
    logic              ifid_load;
    logic              ifid_bubble;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (pc_load),
        .load_pc(redirect_pc),
        .inc    (pc_inc),
        .pc     (pc)
    );

    // stall_ifid alone is a full hold so the word on imem_rdata is never dropped
    assign hold        = pc_stall | stall_ifid;
    assign pc_plus1    = pc + WORD_W'(1);
    assign imem_addr   = pc;
    assign fetch_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FS_BOOT;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Per-edge resolution: redirect, then hold, then advance; BOOT does nothing
    always_comb begin
        state_nxt   = state_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state_q)
            FS_BOOT: begin
                state_nxt = FS_RUN;
            end
            FS_RUN, FS_STALL: begin
                if (redirect_valid) begin
                    pc_load     = 1'b1;
                    ifid_bubble = 1'b1;
                    state_nxt   = FS_RUN;
                end else if (hold) begin
                    ifid_bubble = ~stall_ifid;
                    state_nxt   = FS_STALL;
                end else begin
                    pc_inc    = 1'b1;
                    ifid_load = 1'b1;
                    state_nxt = FS_RUN;
                end
            end
            default: begin
                state_nxt = FS_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_id    <= NOP_INSTR;
            pc_id       <= '0;
            pc_plus1_id <= '0;
            valid_id    <= 1'b0;
        end else if (ifid_load) begin
            instr_id    <= imem_rdata;
            pc_id       <= pc;
            pc_plus1_id <= pc_plus1;
            valid_id    <= 1'b1;
        end else if (ifid_bubble) begin
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
        end
    end

    // Saturating count of stalled cycles outside BOOT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (pc_stall && (state_q != FS_BOOT) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + WORD_W'(1);
        end
    end

endmodule
